prco_board_ctl: RTL and testbench

Parametrised board-control block for PRCO core FPGA tops. It sequences the core's reset and enable, and debounces the DIP switches into a soft-reset request and a debug-page select. It multiplexes NUM_CH debug channels onto the board LEDs, optionally pulse-stretching them so that fast strobes (UART TX, instruction clock) remain visible. It sits between the board pins and the core instance in every board top, replacing the one-shot hard-coded reset and LED assignment.

---
 rtl/prco_board_ctl.sv | 209 ++++++++++++++++++++
 tb/tb_prco_board_ctl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prco_board_ctl.sv
// -----------------------------------------------------------------------------
// prco_board_ctl
//
// Board-control block for PRCO core FPGA tops. Sequences the core reset and
// enable, debounces the DIP switches into a soft-reset request (MSB) and a
// debug-page select (remaining bits), and multiplexes NUM_CH debug channels
// onto the board LEDs.
//
// Optional feature macro: PRCO_LED_STRETCH_EN
//   defined   : every LED bit is pulse-stretched to at least STRETCH_CYCLES+1
//               cycles so that fast strobes stay visible.
//   undefined : q_leds is the registered selected channel, no stretching.
//
// Ports:
//   i_clk        in   1              system clock, single domain
//   i_reset      in   1              synchronous active-high reset
//   i_sw         in   SW_W           raw DIP switches (asynchronous)
//   i_dbg        in   NUM_CH*LED_W   debug channels, ch k at [k*LED_W +: LED_W]
//   q_core_reset out  1              core reset, active-high
//   q_core_en    out  1              core enable
//   q_leds       out  LED_W          LED drive, 1 = lit
//   q_sel        out  SW_W-1         accepted page select
// -----------------------------------------------------------------------------
module prco_board_ctl #(
  parameter int NUM_CH         = 4,
  parameter int LED_W          = 8,
  parameter int SW_W           = 4,
  parameter int RST_HOLD       = 16,
  parameter int DEB_CYCLES     = 4,
  parameter int STRETCH_CYCLES = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [SW_W-1:0]         i_sw,
  input  logic [NUM_CH*LED_W-1:0] i_dbg,
  output logic                    q_core_reset,
  output logic                    q_core_en,
  output logic [LED_W-1:0]        q_leds,
  output logic [SW_W-2:0]         q_sel
);

  localparam int SEL_W = SW_W - 1;
  localparam int DCW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int HCW   = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic {
    S_HOLD,
    S_RUN
  } state_e;

  // ---------------------------------------------------------------------------
  // Switch synchroniser and per-bit debounce
  // ---------------------------------------------------------------------------
  logic [SW_W-1:0] sync1_q, sync2_q;
  logic [SW_W-1:0] deb_q, deb_d;
  logic [DCW-1:0]  deb_cnt_q [SW_W];
  logic [DCW-1:0]  deb_cnt_d [SW_W];

  // The counter tracks how many consecutive cycles the synchronised bit has
  // disagreed with the accepted value; any agreement restarts it.
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    deb_d = deb_q;
    for (int b = 0; b < SW_W; b++) begin
      deb_cnt_d[b] = '0;
      if (sync2_q[b] != deb_q[b]) begin
        if (deb_cnt_q[b] == DCW'(DEB_CYCLES - 1)) begin
          deb_d[b] = sync2_q[b];
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DCW'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int b = 0; b < SW_W; b++) deb_cnt_q[b] <= '0;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int b = 0; b < SW_W; b++) deb_cnt_q[b] <= deb_cnt_d[b];
    end
  end

  logic             soft_rst;
  logic [SEL_W-1:0] sel;

  assign soft_rst = deb_q[SW_W-1];
  assign sel      = deb_q[SEL_W-1:0];
  assign q_sel    = sel;

  // ---------------------------------------------------------------------------
  // Core reset sequencer
  // ---------------------------------------------------------------------------
  state_e         state_q;
  logic [HCW-1:0] hold_q;
  logic           core_reset_q, core_en_q;

  // The hold counter is reloaded for as long as soft reset is asserted, so the
  // RST_HOLD reset cycles are always counted from its release.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_HOLD;
      hold_q       <= HCW'(RST_HOLD - 1);
      core_reset_q <= 1'b1;
      core_en_q    <= 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (soft_rst) begin
            hold_q <= HCW'(RST_HOLD - 1);
          end else if (hold_q != '0) begin
            hold_q <= hold_q - HCW'(1);
          end else begin
            state_q      <= S_RUN;
            core_reset_q <= 1'b0;
            core_en_q    <= 1'b1;
          end
        end
        S_RUN: begin
          if (soft_rst) begin
            state_q      <= S_HOLD;
            hold_q       <= HCW'(RST_HOLD - 1);
            core_reset_q <= 1'b1;
            core_en_q    <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_HOLD;
          hold_q       <= HCW'(RST_HOLD - 1);
          core_reset_q <= 1'b1;
          core_en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign q_core_reset = core_reset_q;
  assign q_core_en    = core_en_q;

  // ---------------------------------------------------------------------------
  // LED path
  // ---------------------------------------------------------------------------
  logic [LED_W-1:0] din;
  logic [LED_W-1:0] leds_q, leds_d;

  // Out-of-range selects match no channel and leave the LEDs dark.
  always_comb begin
    din = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) din = i_dbg[k*LED_W +: LED_W];
    end
  end

`ifdef PRCO_LED_STRETCH_EN
  localparam int SCW = $clog2(STRETCH_CYCLES + 1);

  logic [SCW-1:0]   str_cnt_q [LED_W];
  logic [SCW-1:0]   str_cnt_d [LED_W];
  logic [SEL_W-1:0] sel_prev_q;
  logic             sel_chg;

  // A select change on the previous edge discards the old page's pending
  // stretch before the new page's data is considered.
  assign sel_chg = (sel != sel_prev_q);

  always_comb begin
    leds_d = '0;
    for (int b = 0; b < LED_W; b++) begin
      if (din[b]) begin
        str_cnt_d[b] = SCW'(STRETCH_CYCLES);
      end else if (!sel_chg && str_cnt_q[b] != '0) begin
        str_cnt_d[b] = str_cnt_q[b] - SCW'(1);
      end else begin
        str_cnt_d[b] = '0;
      end
      leds_d[b] = din[b] | (!sel_chg && str_cnt_q[b] != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sel_prev_q <= '0;
      for (int b = 0; b < LED_W; b++) str_cnt_q[b] <= '0;
    end else begin
      sel_prev_q <= sel;
      for (int b = 0; b < LED_W; b++) str_cnt_q[b] <= str_cnt_d[b];
    end
  end
`else
  assign leds_d = din;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) leds_q <= '0;
    else         leds_q <= leds_d;
  end

  assign q_leds = leds_q;

endmodule

// File: tb/tb_prco_board_ctl.sv
// -----------------------------------------------------------------------------
// tb_prco_board_ctl
//
// Directed bench for prco_board_ctl with a cycle-level behavioural model:
//   - debounce as "last DEB_CYCLES synchronised samples all disagree",
//   - reset as "cycles of core reset still owed",
//   - stretch as "edge number of the last 1 on each LED bit".
// The model is compared against the DUT on every falling edge; a few literal
// expectations at known edges pin the model itself.
// -----------------------------------------------------------------------------
module tb_prco_board_ctl;

  localparam int NUM_CH         = 4;
  localparam int LED_W          = 8;
  localparam int SW_W           = 4;
  localparam int SEL_W          = SW_W - 1;
  localparam int RST_HOLD       = 16;
  localparam int DEB_CYCLES     = 4;
  localparam int STRETCH_CYCLES = 8;

`ifdef PRCO_LED_STRETCH_EN
  localparam int PULSE_LIT = STRETCH_CYCLES + 1;
`else
  localparam int PULSE_LIT = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [SW_W-1:0]         sw  = '0;
  logic [NUM_CH*LED_W-1:0] dbg = '0;
  logic                    core_reset, core_en;
  logic [LED_W-1:0]        leds;
  logic [SEL_W-1:0]        sel;

  int total = 0;
  int bad   = 0;

  prco_board_ctl #(
    .NUM_CH        (NUM_CH),
    .LED_W         (LED_W),
    .SW_W          (SW_W),
    .RST_HOLD      (RST_HOLD),
    .DEB_CYCLES    (DEB_CYCLES),
    .STRETCH_CYCLES(STRETCH_CYCLES)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_sw        (sw),
    .i_dbg       (dbg),
    .q_core_reset(core_reset),
    .q_core_en   (core_en),
    .q_leds      (leds),
    .q_sel       (sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [LED_W-1:0] v);
    dbg[k*LED_W +: LED_W] = v;
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int              edge_n = 0;
  bit              model_live = 1'b0;
  logic [SW_W-1:0] m_s1, m_s2;                 // two-stage synchroniser
  logic [SW_W-1:0] m_hist [DEB_CYCLES];        // synchronised samples, [0] newest
  logic [SW_W-1:0] m_deb;
  int              m_owed;                     // core reset cycles still owed
  logic [SEL_W-1:0] m_sel_prev;
  bit              m_valid [LED_W];
  int              m_last  [LED_W];
  logic [LED_W-1:0] exp_leds;

  always @(posedge clk) begin
    logic             soft_old;
    logic [SEL_W-1:0] sel_old;
    logic [LED_W-1:0] data;
    bit               all_diff;
    edge_n++;
    model_live = 1'b1;
    if (rst) begin
      m_s1       = '0;
      m_s2       = '0;
      m_deb      = '0;
      for (int j = 0; j < DEB_CYCLES; j++) m_hist[j] = '0;
      m_owed     = RST_HOLD;
      m_sel_prev = '0;
      for (int b = 0; b < LED_W; b++) m_valid[b] = 1'b0;
      exp_leds   = '0;
    end else begin
      soft_old = m_deb[SW_W-1];
      sel_old  = m_deb[SEL_W-1:0];

      // LEDs: selected channel data, optionally stretched
      data = '0;
      for (int k = 0; k < NUM_CH; k++)
        if (int'(sel_old) == k) data = dbg[k*LED_W +: LED_W];
`ifdef PRCO_LED_STRETCH_EN
      if (sel_old != m_sel_prev)
        for (int b = 0; b < LED_W; b++) m_valid[b] = 1'b0;
      for (int b = 0; b < LED_W; b++) begin
        exp_leds[b] = data[b] || (m_valid[b] && (edge_n - m_last[b] <= STRETCH_CYCLES));
        if (data[b]) begin
          m_valid[b] = 1'b1;
          m_last[b]  = edge_n;
        end
      end
`else
      exp_leds = data;
`endif
      m_sel_prev = sel_old;

      // Reset owed: full RST_HOLD while soft reset is seen, then count down
      if (soft_old)        m_owed = RST_HOLD;
      else if (m_owed > 0) m_owed--;

      // Debounce: accept a bit when the last DEB_CYCLES samples all disagree
      for (int j = DEB_CYCLES - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_s2;
      for (int b = 0; b < SW_W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB_CYCLES; j++)
          if (m_hist[j][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) m_deb[b] = ~m_deb[b];
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  // Single compare process: every falling edge once the model has started
  always @(negedge clk) begin
    if (model_live) begin
      check("core_reset", 32'(core_reset), 32'(m_owed > 0));
      check("core_en",    32'(core_en),    32'(m_owed == 0));
      check("sel",        32'(sel),        32'(m_deb[SEL_W-1:0]));
      check("leds",       32'(leds),       32'(exp_leds));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ---------------------------------------------------------------------------
  initial begin
    int lit;

    // Power-up reset: 3 cycles of i_reset, then exactly 16 cycles of core reset
    rst = 1'b1;
    tick(3);
    check("por_leds", 32'(leds), 32'h0);
    check("por_sel",  32'(sel),  32'h0);
    rst = 1'b0;
    tick(15);
    check("por_hold_last", 32'(core_reset), 32'h1);
    tick(1);
    check("por_release_rst", 32'(core_reset), 32'h0);
    check("por_release_en",  32'(core_en),    32'h1);

    // Debug channels
    set_ch(0, 8'h00);
    set_ch(1, 8'h3C);
    set_ch(2, 8'hA5);
    set_ch(3, 8'hFF);

    // Debounce: bounce 2/0/2/0, then settle on 2
    sw = 4'b0010; tick(1);
    sw = 4'b0000; tick(1);
    sw = 4'b0010; tick(1);
    sw = 4'b0000; tick(1);
    sw = 4'b0010;
    tick(5);
    check("deb_not_yet", 32'(sel), 32'h0);
    tick(1);
    check("deb_accept", 32'(sel), 32'h2);
    tick(1);
    check("page2_leds", 32'(leds), 32'hA5);

    // Out-of-range page
    sw = 4'b0101;
    tick(7);
    check("page5_sel",  32'(sel),  32'h5);
    check("page5_leds", 32'(leds), 32'h00);

    // Page 1 and one-cycle LED latency
    sw = 4'b0001;
    tick(7);
    check("page1_leds", 32'(leds), 32'h3C);
    set_ch(1, 8'h81);
    tick(1);
    check("led_latency", 32'(leds), 32'h81);

    // Single-cycle pulse on channel 0 bit 1
    sw = 4'b0000;
    tick(8);
    set_ch(0, 8'h02);
    tick(1);
    set_ch(0, 8'h00);
    lit = int'(leds[1]);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      lit += int'(leds[1]);
    end
    check("pulse_lit_cycles", 32'(lit), 32'(PULSE_LIT));

    // Page switch while a pulse is being stretched: q_sel moves 6 edges after
    // the switch, the pulse lands 3 edges after it
    sw = 4'b0001;
    tick(2);
    set_ch(0, 8'h02);
    tick(1);
    set_ch(0, 8'h00);
    tick(3);
    check("switch_sel", 32'(sel), 32'h1);
    tick(1);
    check("switch_clears", 32'(leds), 32'h81);

    // Soft reset held 50 cycles
    sw = 4'b1001;
    tick(6);
    check("soft_not_yet", 32'(core_reset), 32'h0);
    tick(1);
    check("soft_asserted", 32'(core_reset), 32'h1);
    check("soft_en_low",   32'(core_en),    32'h0);
    tick(43);
    sw = 4'b0001;
    tick(21);
    check("soft_hold_last", 32'(core_reset), 32'h1);
    tick(1);
    check("soft_release_rst", 32'(core_reset), 32'h0);
    check("soft_release_en",  32'(core_en),    32'h1);

    // i_reset during a held soft reset: hold restarts at RST_HOLD
    sw = 4'b1001;
    tick(20);
    check("mid_in_hold", 32'(core_reset), 32'h1);
    sw  = 4'b0000;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_reset", 32'(core_reset), 32'h1);
    check("mid_rst_en",    32'(core_en),    32'h0);
    check("mid_rst_sel",   32'(sel),        32'h0);
    check("mid_rst_leds",  32'(leds),       32'h0);
    tick(15);
    check("mid_hold_last", 32'(core_reset), 32'h1);
    tick(1);
    check("mid_release", 32'(core_reset), 32'h0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
